// File: rtl/bsg_gateway_tag_serializer.sv
// Serializes tag packets (start bit, nodeid, data_not_reset, len, payload) onto a one-bit tag line.
// Define BSG_GATEWAY_TAG_SER_GAP_EN to insert an 8-cycle quiet gap after each packet.
module bsg_gateway_tag_serializer #(
    parameter int num_masters_p       = 2,
    parameter int els_p               = 1024,
    parameter int lg_width_p          = 4,
    parameter int max_payload_width_p = 15
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    input  logic                           v_i,
    input  logic [num_masters_p-1:0]       masters_i,
    input  logic [$clog2(els_p)-1:0]       nodeid_i,
    input  logic                           data_not_reset_i,
    input  logic [lg_width_p-1:0]          len_i,
    input  logic [max_payload_width_p-1:0] payload_i,
    output logic                           ready_o,
    output logic                           tag_data_o,
    output logic [num_masters_p-1:0]       tag_en_o,
    output logic                           busy_o,
    output logic [15:0]                    pkt_count_o
);

    localparam int lg_els_lp   = $clog2(els_p);
    localparam int hdr_bits_lp = 2 + lg_els_lp + lg_width_p;
    localparam int cnt_max_lp  = (hdr_bits_lp > max_payload_width_p) ? hdr_bits_lp : max_payload_width_p;
    localparam int cnt_w_lp    = $clog2(cnt_max_lp + 1);

    localparam logic [cnt_w_lp-1:0] hdr_last_lp = cnt_w_lp'(hdr_bits_lp - 1);
    localparam logic [cnt_w_lp-1:0] cnt_one_lp  = cnt_w_lp'(1);

    typedef enum logic [1:0] {
        IDLE,
        HDR,
        PAYLOAD
`ifdef BSG_GATEWAY_TAG_SER_GAP_EN
        , GAP
`endif
    } state_e;

    state_e                         st_q, st_d;
    logic [cnt_w_lp-1:0]            cnt_q, cnt_d;
    logic [num_masters_p-1:0]       masters_q, masters_d;
    logic [lg_els_lp-1:0]           nodeid_q, nodeid_d;
    logic                           dnr_q, dnr_d;
    logic [lg_width_p-1:0]          len_q, len_d;
    logic [max_payload_width_p-1:0] payload_q, payload_d;
    logic                           tag_data_q, tag_data_d;
    logic [num_masters_p-1:0]       tag_en_q, tag_en_d;
    logic [15:0]                    pkt_count_q, pkt_count_d;
`ifdef BSG_GATEWAY_TAG_SER_GAP_EN
    logic [2:0]                     gap_cnt_q, gap_cnt_d;
`endif

    logic                           last_bit_c;
    logic [lg_width_p-1:0]          len_clamped_c;
    logic [hdr_bits_lp-1:0]         hdr_vec_c, hdr_sh_c;
    logic [max_payload_width_p-1:0] pl_sh_c;

    always_comb begin
        st_d          = st_q;
        cnt_d         = cnt_q;
        masters_d     = masters_q;
        nodeid_d      = nodeid_q;
        dnr_d         = dnr_q;
        len_d         = len_q;
        payload_d     = payload_q;
        pkt_count_d   = pkt_count_q;
        last_bit_c    = 1'b0;
`ifdef BSG_GATEWAY_TAG_SER_GAP_EN
        gap_cnt_d     = gap_cnt_q;
`endif
        // Clamping at latch time keeps the sent len field and the payload count consistent.
        len_clamped_c = (32'(len_i) > max_payload_width_p) ? lg_width_p'(max_payload_width_p) : len_i;

        case (st_q)
            IDLE: begin
                if (v_i) begin
                    masters_d = masters_i;
                    nodeid_d  = nodeid_i;
                    dnr_d     = data_not_reset_i;
                    len_d     = len_clamped_c;
                    payload_d = payload_i;
                    cnt_d     = '0;
                    st_d      = HDR;
                end
            end
            HDR: begin
                if (cnt_q == hdr_last_lp) begin
                    cnt_d = '0;
                    if (len_q != '0) st_d = PAYLOAD;
                    else             last_bit_c = 1'b1;
                end else begin
                    cnt_d = cnt_q + cnt_one_lp;
                end
            end
            PAYLOAD: begin
                if (cnt_q + cnt_one_lp == cnt_w_lp'(len_q)) begin
                    cnt_d      = '0;
                    last_bit_c = 1'b1;
                end else begin
                    cnt_d = cnt_q + cnt_one_lp;
                end
            end
`ifdef BSG_GATEWAY_TAG_SER_GAP_EN
            GAP: begin
                if (gap_cnt_q == 3'd7) st_d = IDLE;
                else                   gap_cnt_d = gap_cnt_q + 3'd1;
            end
`endif
            default: st_d = IDLE;
        endcase

        if (last_bit_c) begin
`ifdef BSG_GATEWAY_TAG_SER_GAP_EN
            st_d      = GAP;
            gap_cnt_d = '0;
`else
            st_d      = IDLE;
`endif
            if (pkt_count_q != 16'hFFFF) pkt_count_d = pkt_count_q + 16'd1;
        end

        // Outputs are registered, so the bit for the next cycle is picked from next-state values.
        hdr_vec_c  = {len_d, dnr_d, nodeid_d, 1'b1};
        hdr_sh_c   = hdr_vec_c >> cnt_d;
        pl_sh_c    = payload_d >> cnt_d;
        tag_data_d = 1'b0;
        tag_en_d   = '0;
        if (st_d == HDR) begin
            tag_data_d = hdr_sh_c[0];
            tag_en_d   = masters_d;
        end else if (st_d == PAYLOAD) begin
            tag_data_d = pl_sh_c[0];
            tag_en_d   = masters_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            st_q        <= IDLE;
            cnt_q       <= '0;
            masters_q   <= '0;
            nodeid_q    <= '0;
            dnr_q       <= 1'b0;
            len_q       <= '0;
            payload_q   <= '0;
            tag_data_q  <= 1'b0;
            tag_en_q    <= '0;
            pkt_count_q <= '0;
`ifdef BSG_GATEWAY_TAG_SER_GAP_EN
            gap_cnt_q   <= '0;
`endif
        end else begin
            st_q        <= st_d;
            cnt_q       <= cnt_d;
            masters_q   <= masters_d;
            nodeid_q    <= nodeid_d;
            dnr_q       <= dnr_d;
            len_q       <= len_d;
            payload_q   <= payload_d;
            tag_data_q  <= tag_data_d;
            tag_en_q    <= tag_en_d;
            pkt_count_q <= pkt_count_d;
`ifdef BSG_GATEWAY_TAG_SER_GAP_EN
            gap_cnt_q   <= gap_cnt_d;
`endif
        end
    end

    assign ready_o     = (st_q == IDLE);
    assign busy_o      = (st_q != IDLE);
    assign tag_data_o  = tag_data_q;
    assign tag_en_o    = tag_en_q;
    assign pkt_count_o = pkt_count_q;

endmodule

// File: tb/tb_bsg_gateway_tag_serializer.sv
// Directed plus randomized checks of bsg_gateway_tag_serializer against a packet-level bit-list model.
module tb_bsg_gateway_tag_serializer;

    localparam int NM   = 2;
    localparam int ELS  = 16;
    localparam int LGW  = 4;
    localparam int MAXP = 8;
`ifdef BSG_GATEWAY_TAG_SER_GAP_EN
    localparam int GAP_IDLE = 9;
`else
    localparam int GAP_IDLE = 1;
`endif

    logic            clk = 1'b0;
    logic            reset_i;
    logic            v_i;
    logic [NM-1:0]   masters_i;
    logic [3:0]      nodeid_i;
    logic            data_not_reset_i;
    logic [LGW-1:0]  len_i;
    logic [MAXP-1:0] payload_i;
    logic            ready_o;
    logic            tag_data_o;
    logic [NM-1:0]   tag_en_o;
    logic            busy_o;
    logic [15:0]     pkt_count_o;

    always #5 clk = ~clk;

    bsg_gateway_tag_serializer #(
        .num_masters_p(NM), .els_p(ELS), .lg_width_p(LGW), .max_payload_width_p(MAXP)
    ) dut (
        .clk_i(clk), .reset_i(reset_i), .v_i(v_i), .masters_i(masters_i),
        .nodeid_i(nodeid_i), .data_not_reset_i(data_not_reset_i), .len_i(len_i),
        .payload_i(payload_i), .ready_o(ready_o), .tag_data_o(tag_data_o),
        .tag_en_o(tag_en_o), .busy_o(busy_o), .pkt_count_o(pkt_count_o)
    );

    int tests = 0;
    int fails = 0;
    int model_cnt = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected packet as a plain list of bits in transmit order.
    function automatic void build_exp(input logic [3:0] nid, input logic dnr, input logic [3:0] len,
                                      input logic [7:0] pl, output logic [63:0] bits, output int n);
        int l;
        l    = (int'(len) > MAXP) ? MAXP : int'(len);
        bits = '0;
        n    = 0;
        bits[n] = 1'b1; n++;
        for (int i = 0; i < 4; i++) begin bits[n] = nid[i]; n++; end
        bits[n] = dnr; n++;
        for (int i = 0; i < 4; i++) begin bits[n] = l[i]; n++; end
        for (int i = 0; i < l; i++) begin bits[n] = pl[i]; n++; end
    endfunction

    function automatic int sat_inc(input int c);
        return (c >= 16'hFFFF) ? 16'hFFFF : c + 1;
    endfunction

    task automatic send_pkt(input string tag, input logic [1:0] mask, input logic [3:0] nid,
                            input logic dnr, input logic [3:0] len, input logic [7:0] pl,
                            output logic [63:0] obs, output int nobs);
        logic [63:0] e_bits;
        int          e_n;
        int          waited;
        logic        en_ok;
        waited = 0;
        while (ready_o !== 1'b1 && waited < 100) begin @(negedge clk); waited++; end
        check({tag, "_ready"}, 64'(ready_o), 64'd1);
        v_i = 1'b1; masters_i = mask; nodeid_i = nid; data_not_reset_i = dnr;
        len_i = len; payload_i = pl;
        @(negedge clk);
        v_i = 1'b0;
        check({tag, "_busy"}, 64'({busy_o, ready_o}), 64'b10);
        obs = '0; nobs = 0; en_ok = 1'b1;
        while (tag_en_o !== '0 && nobs < 60) begin
            obs[nobs] = tag_data_o;
            if (tag_en_o !== mask) en_ok = 1'b0;
            nobs++;
            @(negedge clk);
        end
        build_exp(nid, dnr, len, pl, e_bits, e_n);
        model_cnt = sat_inc(model_cnt);
        check({tag, "_nbits"}, 64'(nobs), 64'(e_n));
        check({tag, "_bits"}, obs, e_bits);
        check({tag, "_en"}, 64'(en_ok), 64'd1);
        check({tag, "_idle_data"}, 64'(tag_data_o), 64'd0);
        check({tag, "_count"}, 64'(pkt_count_o), 64'(model_cnt));
    endtask

    initial begin
        logic [63:0] obs;
        int          nobs;
        logic [63:0] e_bits;
        int          e_n;
        logic        en_hist[$];
        logic        dat_hist[$];
        int          starts, errs, per, exp_len;
        logic        prev_en, en_now, exp_en, exp_dat;

        reset_i = 1'b1; v_i = 1'b0; masters_i = '0; nodeid_i = '0;
        data_not_reset_i = 1'b0; len_i = '0; payload_i = '0;
        repeat (3) @(negedge clk);
        check("rst_outputs", 64'({tag_data_o, tag_en_o, busy_o, pkt_count_o}), 64'd0);
        reset_i = 1'b0;
        check("rst_ready", 64'(ready_o), 64'd1);

        // Basic data packet with the literal expected stream.
        send_pkt("basic", 2'b01, 4'd3, 1'b1, 4'd4, 8'b0000_1010, obs, nobs);
        check("basic_literal", obs, 64'b10100100100111);

        // Client-reset packet: header only.
        send_pkt("rstpkt", 2'b10, 4'd15, 1'b0, 4'd0, 8'hFF, obs, nobs);
        check("rstpkt_literal", obs, 64'b0000011111);
        @(negedge clk);
        check("rstpkt_ready", 64'(ready_o), 64'd1);

        // Length clamp: len field reads 8, then 8 payload bits.
        send_pkt("clamp", 2'b11, 4'd5, 1'b1, 4'd15, 8'hA5, obs, nobs);
        check("clamp_lenfield", 64'((obs >> 6) & 64'hF), 64'd8);

        // Reset arriving mid-packet.
        v_i = 1'b1; masters_i = 2'b01; nodeid_i = 4'd9; data_not_reset_i = 1'b1;
        len_i = 4'd6; payload_i = 8'h3C;
        @(negedge clk);
        v_i = 1'b0;
        repeat (5) @(negedge clk);
        reset_i = 1'b1;
        @(negedge clk);
        check("midrst_outputs", 64'({tag_data_o, tag_en_o, busy_o, pkt_count_o}), 64'd0);
        reset_i = 1'b0;
        model_cnt = 0;
        check("midrst_ready", 64'(ready_o), 64'd1);
        send_pkt("after_rst", 2'b10, 4'd6, 1'b1, 4'd3, 8'h05, obs, nobs);

        // Randomized packets.
        for (int k = 0; k < 16; k++) begin
            send_pkt("rand", 2'($urandom_range(1, 3)), 4'($urandom_range(0, 15)),
                     1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                     8'($urandom_range(0, 255)), obs, nobs);
        end

        // Back-to-back: v_i held across three packets.
        @(negedge clk);
        build_exp(4'd12, 1'b1, 4'd2, 8'h02, e_bits, e_n);
        v_i = 1'b1; masters_i = 2'b11; nodeid_i = 4'd12; data_not_reset_i = 1'b1;
        len_i = 4'd2; payload_i = 8'h02;
        starts = 0; prev_en = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            en_now = (tag_en_o !== '0);
            if (en_now && !prev_en) begin
                starts++;
                if (starts == 3) v_i = 1'b0;
            end
            en_hist.push_back(en_now);
            dat_hist.push_back(tag_data_o);
            if (starts == 3 && !en_now && prev_en) break;
            prev_en = en_now;
        end
        v_i = 1'b0;
        per     = e_n + GAP_IDLE;
        exp_len = 3 * e_n + 2 * GAP_IDLE + 1;
        errs    = 0;
        for (int k = 0; k < en_hist.size(); k++) begin
            exp_en  = (k < 3 * per - GAP_IDLE) && ((k % per) < e_n);
            exp_dat = exp_en ? e_bits[k % per] : 1'b0;
            if (en_hist[k] !== exp_en || dat_hist[k] !== exp_dat) errs++;
        end
        for (int p = 0; p < 3; p++) model_cnt = sat_inc(model_cnt);
        check("b2b_len", 64'(en_hist.size()), 64'(exp_len));
        check("b2b_stream_errs", 64'(errs), 64'd0);
        check("b2b_count", 64'(pkt_count_o), 64'(model_cnt));

        // Saturation of the packet counter.
        @(negedge clk);
        force dut.pkt_count_q = 16'hFFFE;
        @(negedge clk);
        release dut.pkt_count_q;
        model_cnt = 16'hFFFE;
        @(negedge clk);
        check("sat_preset", 64'(pkt_count_o), 64'hFFFE);
        send_pkt("sat1", 2'b01, 4'd1, 1'b1, 4'd1, 8'h01, obs, nobs);
        send_pkt("sat2", 2'b01, 4'd2, 1'b0, 4'd0, 8'h00, obs, nobs);
        check("sat_final", 64'(pkt_count_o), 64'hFFFF);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/bsg_gateway_tag_serializer.md
BSG_GATEWAY_TAG_SERIALIZER -- requirements
Module: bsg_gateway_tag_serializer

Interface
REQ-001 The block SHALL have parameter num_masters_p, default 2, giving the number of tag masters (one enable bit each).
REQ-002 The block SHALL have parameter els_p, default 1024, giving the number of tag clients; node-id width lg_els = clog2(els_p).
REQ-003 The block SHALL have parameter lg_width_p, default 4, giving the width of the payload-length field.
REQ-004 The block SHALL have parameter max_payload_width_p, default 15, giving the maximum payload bits per packet.
REQ-005 clk_i  input  1  tag clock; all state is updated on its rising edge.
REQ-006 reset_i  input  1  synchronous, active-high reset.
REQ-007 v_i  input  1  packet request valid.
REQ-008 masters_i  input  num_masters_p  master enable mask for the packet.
REQ-009 nodeid_i  input  lg_els  destination client id.
REQ-010 data_not_reset_i  input  1  1 = data packet; 0 = client-reset packet.
REQ-011 len_i  input  lg_width_p  payload length in bits.
REQ-012 payload_i  input  max_payload_width_p  payload, LSB sent first.
REQ-013 ready_o  output  1  the block accepts a packet on the cycle v_i & ready_o is high.
REQ-014 tag_data_o  output  1  registered serial tag data.
REQ-015 tag_en_o  output  num_masters_p  registered per-master enable.
REQ-016 busy_o  output  1  high whenever the state is not IDLE.
REQ-017 pkt_count_o  output  16  count of completed packets; saturates at 16'hFFFF.

Function
REQ-018 FSM states SHALL be IDLE, HDR, PAYLOAD, GAP; ready_o SHALL be 1 only in IDLE.
REQ-019 On accept, the block SHALL latch all inputs and go to HDR; the first bit SHALL appear on tag_data_o on the cycle after accept.
REQ-020 Header SHALL be 2+lg_els+lg_width_p bits, sent in this order, one per cycle:
- start bit 1
- nodeid, LSB first
- data_not_reset
- len, LSB first
REQ-021 After the header, with latched len > 0, the FSM SHALL enter PAYLOAD and send len payload bits, LSB first.
REQ-022 With latched len = 0, the FSM SHALL skip PAYLOAD.
REQ-023 A len_i greater than max_payload_width_p SHALL be clamped to max_payload_width_p, both in the transmitted len field and in the payload bit count.
REQ-024 tag_en_o SHALL equal the latched mask on every cycle a packet bit is driven, and SHALL be 0 otherwise.
REQ-025 tag_data_o SHALL be 0 whenever tag_en_o is 0.
REQ-026 pkt_count_o SHALL increment on the cycle the last packet bit is driven.
REQ-027 Without the gap feature (REQ-032), the FSM SHALL return to IDLE after the last bit, so back-to-back packets have one idle cycle between them.
REQ-028 A v_i held while ready_o=0 SHALL be ignored (not latched), with no loss of a packet already in flight.
REQ-029 The bit counter SHALL be wide enough for max(header, max_payload_width_p) and SHALL reset to 0 at each state entry.

Reset
REQ-030 When reset_i is high, the block SHALL enter IDLE and drive tag_data_o=0, tag_en_o=0, busy_o=0, pkt_count_o=0 on the next edge, including when reset arrives mid-packet.
REQ-031 ready_o SHALL be 1 on the first cycle after reset deasserts.

Configuration
REQ-032 With macro BSG_GATEWAY_TAG_SER_GAP_EN defined:
- after each packet the FSM SHALL enter GAP and hold 8 cycles with tag_en_o=0 and tag_data_o=0 before IDLE;
- busy_o SHALL stay 1 during GAP.
REQ-033 With BSG_GATEWAY_TAG_SER_GAP_EN undefined, the GAP state and its counter SHALL be absent, and the behaviour of REQ-027 applies.

Verification
Bench parameters: els_p=16, lg_width_p=4, max_payload_width_p=8.
REQ-034 Basic packet: nodeid=3, data_not_reset=1, len=4, payload=4'b1010, masters=2'b01 -> tag_data_o = 1,1,1,0,0,1,0,0,1,0,0,1,0,1 over 14 cycles; tag_en_o=01 throughout; pkt_count_o=1.
REQ-035 Reset packet: len=0, data_not_reset=0, nodeid=15 -> 10 header bits 1,1,1,1,1,0,0,0,0,0; no payload bits; ready_o returns to 1.
REQ-036 Clamp: len_i=15 -> len field sent as 8 (0,0,0,1); exactly 8 payload bits follow.
REQ-037 Reset mid-packet: reset_i asserted at bit 5 -> next cycle tag_en_o=0, busy_o=0, pkt_count_o=0; a following packet is sent intact.
REQ-038 Back-to-back: v_i held high for 3 packets -> exactly 1 idle cycle between packets (9 with GAP_EN); pkt_count_o=3.
REQ-039 Saturation: force pkt_count_o to 16'hFFFE, send 2 packets -> pkt_count_o=16'hFFFF.
